// File: rtl/score_bcd_converter_pkg.sv
// Shared types and constants for the score path: BCD converter FSM states, score width
// and digit count used by the score logic, the converter and the number renderer.
package score_bcd_converter_pkg;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_t;

    localparam int unsigned SCORE_W      = 32;
    localparam int unsigned SCORE_DIGITS = 8;

    // Largest value representable in the given number of decimal digits (10^digits - 1).
    function automatic logic [63:0] bcd_max_value(input int unsigned digits);
        logic [63:0] acc;
        acc = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            acc = acc * 64'd10;
        end
        return acc - 64'd1;
    endfunction

    // True when every nibble of a packed BCD word lies in 0..9.
    function automatic logic bcd_digits_valid(input logic [63:0] bcd, input int unsigned digits);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < digits; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 so that the following
// left shift carries correctly into the next decimal digit.
module bcd_add3_cell (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One bit per clock; the packed BCD
// result and overflow flag are held stable between completions.
module score_bcd_converter
    import score_bcd_converter_pkg::*;
#(
    parameter int unsigned IN_W   = SCORE_W,
    parameter int unsigned DIGITS = SCORE_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned      BCD_W    = 4 * DIGITS;
    localparam int unsigned      CNT_W    = $clog2(IN_W + 1);
    localparam logic [63:0]      MAX_VAL  = bcd_max_value(DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam bit               MAX_FITS = (IN_W >= 64) || (MAX_VAL < (64'd1 << IN_W));

    if (MAX_FITS && (BCD_W > 64)) begin : g_bad_cfg
        $error("score_bcd_converter: unsupported IN_W/DIGITS combination");
    end

    bcd_state_t       state;
    logic [IN_W-1:0]  bin_sr;
    logic [BCD_W-1:0] work;
    logic [BCD_W-1:0] work_adj;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pend;

    logic [63:0]      value_ext;
    logic             value_over;
    logic [IN_W-1:0]  sat_val;

    // Clamp to the largest displayable value so the top digit can never carry out.
    always_comb begin
        value_ext  = 64'(value);
        value_over = (value_ext > MAX_VAL);
        sat_val    = value_over ? MAX_VAL[IN_W-1:0] : value;
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3_cell u_add3 (
            .digit    (work[4*d +: 4]),
            .adjusted (work_adj[4*d +: 4])
        );
    end

    assign busy = (state != BCD_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BCD_IDLE;
            bin_sr   <= '0;
            work     <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                BCD_IDLE: begin
                    if (start) begin
                        bin_sr   <= sat_val;
                        ovf_pend <= value_over;
                        work     <= '0;
                        cnt      <= '0;
                        state    <= BCD_SHIFT;
                    end
                end
                BCD_SHIFT: begin
                    {work, bin_sr} <= {work_adj, bin_sr} << 1;
                    cnt            <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= BCD_DONE;
                    end
                end
                BCD_DONE: begin
                    bcd_out  <= work;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    state    <= BCD_IDLE;
                end
                default: begin
                    state <= BCD_IDLE;
                end
            endcase
        end
    end

    a_done_single : assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_bcd_digits  : assert property (@(posedge clk) disable iff (rst)
                                     bcd_digits_valid(64'(bcd_out), DIGITS));
    a_done_idle   : assert property (@(posedge clk) disable iff (rst) done |-> !busy);

endmodule
